regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port register file: the successor to the fixed 16x32 register file. Provides two registered read ports, two synchronous write ports with defined collision priority, an optional hard-wired zero register, and a per-register busy scoreboard so the issue logic can track results still pending from multi-cycle units. Sits between the decode/issue stage (reads, scoreboard set) and the execute/writeback stages (writes, scoreboard clear).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 4, address width; depth = 2^ADDR_W registers
- ZERO_REG, 0, 1 = register 0 always reads 0, ignores writes and is never busy
- clock  input  1  rising-edge clock for all state
- reset_n  input  1  asynchronous, active-low reset
- rd_en  input  1  sample read addresses this edge
- ra, rb  input  ADDR_W  read addresses for ports A and B
- bus_a, bus_b  output  DATA_W  registered read data
- busy_a, busy_b  output  1  registered scoreboard bit of ra / rb
- we1, waddr1, wdata1  input  1 / ADDR_W / DATA_W  write port 1 (primary writeback)
- we2, waddr2, wdata2  input  1 / ADDR_W / DATA_W  write port 2 (load / long-latency writeback)
- sb_set, sb_addr  input  1 / ADDR_W  mark sb_addr busy (producer issued)
- busy_vec  output  2^ADDR_W  current scoreboard, bit i = register i busy

## Operation
- Writes: on rising clock edge, weN=1 stores wdataN at waddrN. Writes are edge-sampled with the enable as a qualifier; the enable is never used as a clock.
- Write collision: we1 and we2 to the same address in the same cycle -> port 1 data stored, port 2 dropped.
- Reads: rd_en=1 at an edge loads bus_a <= reg[ra] and bus_b <= reg[rb], plus busy_a and busy_b. rd_en=0 -> bus_a, bus_b, busy_a and busy_b hold their values.
- Scoreboard: sb_set=1 sets busy[sb_addr]. Any accepted write to address i clears busy[i], including a port 2 write that lost a collision.
- Set and clear of the same address in one cycle -> set wins (a new producer supersedes the old result).
- ZERO_REG=1: writes to address 0 are ignored, reads of 0 return 0, busy[0] is forced to 0, and sb_set to address 0 is ignored.
- Reads of busy_vec are continuous (not gated by rd_en) and reflect the registered state.

## Timing
- Reset (reset_n low, asynchronous): all registers = 0, busy_vec = 0, bus_a = bus_b = 0, busy_a = busy_b = 0. Outputs are held while reset_n is low.
- Reset released mid-operation: first edge with reset_n high behaves as a normal cycle. Writes presented during reset are lost.
- Read latency: 1 cycle. Addresses and rd_en are sampled at edge N, and data is valid after edge N.
- Write visibility without bypass: a write at edge N is readable by a read sampled at edge N+1. A read of the same address at edge N returns the old value and the old busy bit.
- Scoreboard update takes effect at the edge and appears in busy_vec after that edge.

## Configuration
- REGFILE_BYPASS_EN defined: a read sampled at the same edge as a write to the same address returns the new data, using port 1 priority on collision. busy_a and busy_b return the post-update scoreboard value, with set winning over clear.
- REGFILE_BYPASS_EN undefined: no forwarding; same-edge reads return pre-write data and pre-update busy, as described in Timing.

## Test plan
- Reset: write 0xDEADBEEF to r3, then pulse reset_n low between edges -> bus_a/bus_b/busy_vec go 0 immediately, and a later read of r3 returns 0x00000000.
- Basic read/write: we1 r5=0x12345678, next cycle rd_en with ra=5 and rb=0 -> after the following edge bus_a=0x12345678 and bus_b=0. Then hold rd_en=0 for 3 cycles while r5 is rewritten -> bus_a stays 0x12345678.
- Collision: we1 r7=0xAAAA0001 and we2 r7=0x5555_0002 at the same edge, with sb_set r7 issued earlier -> r7 reads 0xAAAA0001 and busy_vec[7]=0.
- Scoreboard priority: sb_set r9 and we1 r9=0x1 at the same edge -> busy_vec[9]=1 and r9=0x1. Next cycle we2 r9=0x2 -> busy_vec[9]=0.
- Zero register (ZERO_REG=1): we1 r0=0xFFFFFFFF plus sb_set r0 -> read of r0 returns 0 and busy_vec[0]=0. With ZERO_REG=0 the same stimulus reads 0xFFFFFFFF.
- Same-cycle read/write on r2: r2 holds 0x11, then we1 r2=0x22 with rd_en ra=2 at the same edge -> bus_a=0x22 with REGFILE_BYPASS_EN, 0x11 without.

Source files
------------

// File: rtl/regfile_mp.sv
// Parametrised 2R/2W register file with per-register busy scoreboard and optional zero register.
// Optional same-edge read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = 0
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    rd_en,
   input  logic [ADDR_W-1:0]       ra,
   input  logic [ADDR_W-1:0]       rb,
   output logic [DATA_W-1:0]       bus_a,
   output logic [DATA_W-1:0]       bus_b,
   output logic                    busy_a,
   output logic                    busy_b,
   input  logic                    we1,
   input  logic [ADDR_W-1:0]       waddr1,
   input  logic [DATA_W-1:0]       wdata1,
   input  logic                    we2,
   input  logic [ADDR_W-1:0]       waddr2,
   input  logic [DATA_W-1:0]       wdata2,
   input  logic                    sb_set,
   input  logic [ADDR_W-1:0]       sb_addr,
   output logic [(1<<ADDR_W)-1:0]  busy_vec
);

   localparam int   DEPTH   = 1 << ADDR_W;
   localparam logic ZERO_EN = (ZERO_REG != 0);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [DEPTH-1:0]  busy_r;
   logic [DEPTH-1:0]  busy_nxt_s;
   logic [DEPTH-1:0]  clr_s;
   logic [DEPTH-1:0]  set_s;
   logic [DEPTH-1:0]  zero_mask_s;
   logic              wr1_s;
   logic              wr2_s;
   logic              sb_ok_s;
   logic [DATA_W-1:0] rdata_a_s;
   logic [DATA_W-1:0] rdata_b_s;
   logic              rbusy_a_s;
   logic              rbusy_b_s;

   // Address 0 is write/set-protected when the zero register is enabled.
   assign wr1_s   = we1    & ~(ZERO_EN & (waddr1  == '0));
   assign wr2_s   = we2    & ~(ZERO_EN & (waddr2  == '0));
   assign sb_ok_s = sb_set & ~(ZERO_EN & (sb_addr == '0));

   // Port 2 clears busy even when its data loses a collision; set beats clear.
   assign clr_s       = ({{(DEPTH-1){1'b0}}, wr1_s} << waddr1) | ({{(DEPTH-1){1'b0}}, wr2_s} << waddr2);
   assign set_s       = {{(DEPTH-1){1'b0}}, sb_ok_s} << sb_addr;
   assign zero_mask_s = {{(DEPTH-1){1'b0}}, ZERO_EN};
   assign busy_nxt_s  = ((busy_r & ~clr_s) | set_s) & ~zero_mask_s;

   assign busy_vec = busy_r;

   // Read-port data/busy selection (optionally forwarded from this edge's updates).
   always_comb begin
      rdata_a_s = mem_r[ra];
      rdata_b_s = mem_r[rb];
      rbusy_a_s = busy_r[ra];
      rbusy_b_s = busy_r[rb];
`ifdef REGFILE_BYPASS_EN
      rbusy_a_s = busy_nxt_s[ra];
      rbusy_b_s = busy_nxt_s[rb];
      if (wr1_s && (waddr1 == ra)) begin
         rdata_a_s = wdata1;
      end else if (wr2_s && (waddr2 == ra)) begin
         rdata_a_s = wdata2;
      end else begin
         rdata_a_s = mem_r[ra];
      end
      if (wr1_s && (waddr1 == rb)) begin
         rdata_b_s = wdata1;
      end else if (wr2_s && (waddr2 == rb)) begin
         rdata_b_s = wdata2;
      end else begin
         rdata_b_s = mem_r[rb];
      end
`endif
   end

   // Register array with port 1 priority on address collision.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr1_s && (waddr1 == ADDR_W'(i))) begin
               mem_r[i] <= wdata1;
            end else if (wr2_s && (waddr2 == ADDR_W'(i))) begin
               mem_r[i] <= wdata2;
            end else begin
               mem_r[i] <= mem_r[i];
            end
         end
      end
   end

   // Busy scoreboard state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         busy_r <= '0;
      end else begin
         busy_r <= busy_nxt_s;
      end
   end

   // Registered read ports; hold when rd_en is low.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bus_a  <= '0;
         bus_b  <= '0;
         busy_a <= 1'b0;
         busy_b <= 1'b0;
      end else if (rd_en) begin
         bus_a  <= rdata_a_s;
         bus_b  <= rdata_b_s;
         busy_a <= rbusy_a_s;
         busy_b <= rbusy_b_s;
      end else begin
         bus_a  <= bus_a;
         bus_b  <= bus_b;
         busy_a <= busy_a;
         busy_b <= busy_b;
      end
   end

endmodule
